// File: rtl/width_16to8.sv
// Downsizing width converter: splits each IN_W-bit word into IN_W/OUT_W beats,
// with valid/ready on both sides and bubble-free streaming of back-to-back words.
module width_16to8 #(
    parameter int IN_W      = 16,
    parameter int OUT_W     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    output logic             ready_in,
    input  logic [IN_W-1:0]  data_in,
    output logic             valid_out,
    input  logic             ready_out,
    output logic [OUT_W-1:0] data_out,
    output logic             last_out
);
    localparam int RATIO = IN_W / OUT_W;
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state;
    logic [IN_W-1:0]  sh;
    logic [CNT_W-1:0] cnt;
    logic             in_fire;
    logic             out_fire;

    assign valid_out = (state == SEND);
    assign last_out  = valid_out && (cnt == LAST_CNT);
    assign data_out  = MSB_FIRST ? sh[IN_W-1 -: OUT_W] : sh[OUT_W-1:0];
    // ready_out feeds ready_in directly so a new word can load as the last beat leaves
    assign ready_in  = !valid_out || (last_out && ready_out);
    assign in_fire   = valid_in && ready_in;
    assign out_fire  = valid_out && ready_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sh    <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_fire) begin
                        sh    <= data_in;
                        cnt   <= '0;
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (out_fire) begin
                        if (!last_out) begin
                            cnt <= cnt + CNT_W'(1);
                            sh  <= MSB_FIRST ? (sh << OUT_W) : (sh >> OUT_W);
                        end else if (in_fire) begin
                            sh  <= data_in;
                            cnt <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_width_16to8.sv
// Self-checking bench for width_16to8: a queue-of-beats model checked every cycle,
// directed literal scenarios, then randomized traffic with a mid-run async reset.
module tb_width_16to8;
    localparam int IN_W  = 16;
    localparam int OUT_W = 8;
    localparam int RATIO = IN_W / OUT_W;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             valid_in = 1'b0;
    logic             ready_out = 1'b0;
    logic [IN_W-1:0]  data_in = '0;
    logic             ready_in, valid_out, last_out;
    logic [OUT_W-1:0] data_out;
    logic             ready_in_l, valid_out_l, last_out_l;
    logic [OUT_W-1:0] data_out_l;

    int checks = 0;
    int passes = 0;

    logic [OUT_W-1:0] exp_q[$];
    logic [OUT_W-1:0] exp_ql[$];
    logic [OUT_W-1:0] seen[$];
    logic [OUT_W-1:0] seen_l[$];
    bit zero_data = 1'b1;
    bit accepted  = 1'b0;

    width_16to8 #(.IN_W(IN_W), .OUT_W(OUT_W), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .valid_in(valid_in), .ready_in(ready_in), .data_in(data_in),
        .valid_out(valid_out), .ready_out(ready_out), .data_out(data_out),
        .last_out(last_out)
    );

    width_16to8 #(.IN_W(IN_W), .OUT_W(OUT_W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n),
        .valid_in(valid_in), .ready_in(ready_in_l), .data_in(data_in),
        .valid_out(valid_out_l), .ready_out(ready_out), .data_out(data_out_l),
        .last_out(last_out_l)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic apply_stimulus(input logic v, input logic [IN_W-1:0] d, input logic r);
        @(posedge clk);
        #1;
        valid_in  = v;
        data_in   = d;
        ready_out = r;
    endtask

    // Model: the words in flight, flattened into the beats still owed downstream.
    always @(negedge clk) begin
        bit exp_valid, exp_last, exp_ready, in_fire, out_fire;
        if (!rst_n) begin
            exp_q.delete();
            exp_ql.delete();
            zero_data = 1'b1;
            accepted  = 1'b0;
            check_output("rst_valid_out", valid_out, 0);
            check_output("rst_last_out", last_out, 0);
            check_output("rst_data_out", data_out, 0);
            check_output("rst_ready_in", ready_in, 1);
            check_output("rst_valid_out_lsb", valid_out_l, 0);
            check_output("rst_data_out_lsb", data_out_l, 0);
        end else begin
            exp_valid = exp_q.size() > 0;
            exp_last  = exp_q.size() == 1;
            exp_ready = (exp_q.size() == 0) || (exp_last && ready_out);
            check_output("valid_out", valid_out, exp_valid);
            check_output("last_out", last_out, exp_last);
            check_output("ready_in", ready_in, exp_ready);
            check_output("valid_out_lsb", valid_out_l, exp_valid);
            check_output("last_out_lsb", last_out_l, exp_last);
            check_output("ready_in_lsb", ready_in_l, exp_ready);
            if (exp_valid) begin
                check_output("data_out", data_out, exp_q[0]);
                check_output("data_out_lsb", data_out_l, exp_ql[0]);
            end else if (zero_data) begin
                check_output("idle_data_zero", data_out, 0);
                check_output("idle_data_zero_lsb", data_out_l, 0);
            end
            in_fire  = valid_in && exp_ready;
            out_fire = exp_valid && ready_out;
            if (out_fire) begin
                seen.push_back(data_out);
                seen_l.push_back(data_out_l);
                void'(exp_q.pop_front());
                void'(exp_ql.pop_front());
            end
            if (in_fire) begin
                for (int k = 0; k < RATIO; k++) begin
                    exp_q.push_back(data_in[IN_W-1-k*OUT_W -: OUT_W]);
                    exp_ql.push_back(data_in[k*OUT_W +: OUT_W]);
                end
                zero_data = 1'b0;
            end
            accepted = in_fire;
        end
    end

    initial begin
        logic [7:0] b2b_data[4];
        logic       b2b_ready[4];
        b2b_data  = '{8'h12, 8'h34, 8'h56, 8'h78};
        b2b_ready = '{1'b0, 1'b1, 1'b0, 1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_output("t1_ready_in", ready_in, 1);
        check_output("t1_valid_out", valid_out, 0);
        check_output("t1_data_out", data_out, 0);

        // Single word, MSB-first and LSB-first instances side by side
        apply_stimulus(1'b1, 16'hA55A, 1'b1);
        apply_stimulus(1'b0, 16'h0000, 1'b1);
        @(negedge clk);
        check_output("t2_beat0", data_out, 8'hA5);
        check_output("t2_last0", last_out, 0);
        check_output("t6_lsb_beat0", data_out_l, 8'h5A);
        @(negedge clk);
        check_output("t2_beat1", data_out, 8'h5A);
        check_output("t2_last1", last_out, 1);
        check_output("t6_lsb_beat1", data_out_l, 8'hA5);
        check_output("t6_lsb_last1", last_out_l, 1);
        @(negedge clk);
        check_output("t2_idle_after", valid_out, 0);

        // Back-to-back words with valid_in held high
        apply_stimulus(1'b1, 16'h1234, 1'b1);
        apply_stimulus(1'b1, 16'h5678, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_output($sformatf("t3_beat%0d", i), data_out, b2b_data[i]);
            check_output($sformatf("t3_valid%0d", i), valid_out, 1);
            check_output($sformatf("t3_ready_in%0d", i), ready_in, b2b_ready[i]);
            check_output($sformatf("t3_last%0d", i), last_out, i % 2);
            if (i == 1) begin
                @(posedge clk);
                #1 valid_in = 1'b0;
            end
        end

        // Downstream stall holds the first beat
        apply_stimulus(1'b0, 16'h0000, 1'b1);
        apply_stimulus(1'b1, 16'hBEEF, 1'b0);
        apply_stimulus(1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output($sformatf("t4_hold%0d", i), data_out, 8'hBE);
            check_output($sformatf("t4_ready_in%0d", i), ready_in, 0);
        end
        apply_stimulus(1'b0, 16'h0000, 1'b1);
        @(negedge clk);
        check_output("t4_beat0", data_out, 8'hBE);
        @(negedge clk);
        check_output("t4_beat1", data_out, 8'hEF);
        check_output("t4_last1", last_out, 1);

        // Async reset mid-word drops the remaining beat
        @(posedge clk);
        seen.delete();
        apply_stimulus(1'b1, 16'hDEAD, 1'b1);
        apply_stimulus(1'b0, 16'h0000, 1'b1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_output("t5_rst_valid", valid_out, 0);
        check_output("t5_rst_data", data_out, 0);
        check_output("t5_rst_last", last_out, 0);
        check_output("t5_rst_ready_in", ready_in, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        apply_stimulus(1'b1, 16'h0102, 1'b1);
        apply_stimulus(1'b0, 16'h0000, 1'b1);
        repeat (3) @(negedge clk);
        check_output("t5_seen_count", seen.size(), 3);
        if (seen.size() == 3) begin
            check_output("t5_seen0", seen[0], 8'hDE);
            check_output("t5_seen1", seen[1], 8'h01);
            check_output("t5_seen2", seen[2], 8'h02);
        end

        // Randomized traffic; upstream holds its word until it is taken
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            if (c == 1500) begin
                #2 rst_n = 1'b0;
                #1;
                check_output("rand_rst_valid", valid_out, 0);
                check_output("rand_rst_data", data_out, 0);
                valid_in = 1'b0;
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
            end else begin
                if (!(valid_in && !accepted)) begin
                    valid_in = ($urandom_range(0, 3) != 0);
                    data_in  = IN_W'($urandom);
                end
                ready_out = ($urandom_range(0, 3) != 0);
            end
        end

        apply_stimulus(1'b0, 16'h0000, 1'b1);
        repeat (4) @(negedge clk);
        check_output("drain_empty", valid_out, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
